// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial two's-complement subtractor, LSB first, start/done handshake
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  // Only WIDTH-1 result bits need storing: the last sum bit goes straight
  // into diff on the final RUN cycle.
  logic [WIDTH-2:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;

  logic             b_inv;
  logic             sum_bit;
  logic             carry_nxt;
  logic [WIDTH-1:0] acc_full;
  logic             last_bit;

  // Full-adder cell computing a + ~b + carry for the current bit position.
  always_comb begin
    b_inv     = ~b_sh_q[0];
    sum_bit   = a_sh_q[0] ^ b_inv ^ carry_q;
    carry_nxt = (a_sh_q[0] & b_inv) | (a_sh_q[0] & carry_q) | (b_inv & carry_q);
    acc_full  = {sum_bit, acc_q};
    last_bit  = (cnt_q == CW'(WIDTH - 1));
  end

  // Next-state logic for the FSM, datapath shift registers and result registers.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          acc_d   = '0;
          carry_d = 1'b1;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        acc_d   = acc_full[WIDTH-1:1];
        carry_d = carry_nxt;
        cnt_d   = cnt_q + CW'(1);
        if (last_bit) begin
          diff_d   = acc_full;
          borrow_d = ~carry_nxt;
          ovf_d    = (a_msb_q != b_msb_q) && (sum_bit != a_msb_q);
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any op and clears the results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  // Outputs come only from registers.
  always_comb begin
    busy       = (state_q == S_RUN) || (state_q == S_DONE);
    done       = (state_q == S_DONE);
    diff       = diff_q;
    borrow_out = borrow_q;
    ovf        = ovf_q;
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor (WIDTH=8 directed, WIDTH=4 sweep)
module tb_serial_subtractor;

  typedef struct {
    int d;
    int br;
    int ov;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       busy8, done8, borrow8, ovf8;
  logic [7:0] diff8;
  logic       start4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       busy4, done4, borrow4, ovf4;
  logic [3:0] diff4;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   done8_cnt = 0;
  int   done4_cnt = 0;
  int   prev_done4 = -1;
  exp_t q8[$];
  exp_t q4[$];

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(borrow8), .ovf(ovf8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(borrow4), .ovf(ovf4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: integer subtraction, signed overflow judged by range of the true signed result.
  function automatic exp_t model(input int w, input int x, input int y);
    exp_t e;
    int   m, sx, sy, sd;
    m    = 1 << w;
    e.d  = (x - y + m) % m;
    e.br = (x < y) ? 1 : 0;
    sx   = (x >= m / 2) ? x - m : x;
    sy   = (y >= m / 2) ? y - m : y;
    sd   = sx - sy;
    e.ov = (sd < -(m / 2) || sd > (m / 2) - 1) ? 1 : 0;
    return e;
  endfunction

  // Scoreboard for the 8-bit instance.
  always @(posedge clk) begin
    #1;
    if (done8) begin
      done8_cnt++;
      if (q8.size() == 0) begin
        check_eq("sb8_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check_eq("diff8", diff8, e.d);
        check_eq("borrow8", borrow8, e.br);
        check_eq("ovf8", ovf8, e.ov);
      end
    end
  end

  // Scoreboard and done-spacing check for the 4-bit instance.
  always @(posedge clk) begin
    #1;
    if (done4) begin
      done4_cnt++;
      if (prev_done4 >= 0) check_eq("gap4", cyc - prev_done4, 6);
      prev_done4 = cyc;
      if (q4.size() == 0) begin
        check_eq("sb4_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        check_eq("diff4", diff4, e.d);
        check_eq("borrow4", borrow4, e.br);
        check_eq("ovf4", ovf4, e.ov);
      end
    end
  end

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input int inject);
    int   n;
    int   cnt0;
    exp_t e;
    e = model(8, ta, tb_v);
    @(negedge clk);
    a8 = ta;
    b8 = tb_v;
    start8 = 1'b1;
    @(posedge clk);
    q8.push_back(e);
    cnt0 = done8_cnt;
    #1;
    start8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) check_eq("busy_after_start", busy8, 1);
      if (inject != 0 && n == inject) begin
        start8 = 1'b1;
        a8 = 8'h11;
        b8 = 8'h22;
      end else begin
        start8 = 1'b0;
      end
      if (done8) break;
    end
    start8 = 1'b0;
    check_eq("latency8", n, 8);
    repeat (3) @(posedge clk);
    #1;
    check_eq("done_pulses", done8_cnt - cnt0, 1);
    check_eq("idle_busy", busy8, 0);
    check_eq("hold_diff", diff8, e.d);
  endtask

  initial begin
    int cnt0;
    int t;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_busy", busy8, 0);
    check_eq("rst_done", done8, 0);
    check_eq("rst_diff", diff8, 0);
    check_eq("rst_borrow", borrow8, 0);
    check_eq("rst_ovf", ovf8, 0);
    check_eq("rst_busy4", busy4, 0);

    run_op(8'd5, 8'd3, 0);
    run_op(8'd3, 8'd5, 0);
    run_op(8'h80, 8'h01, 0);
    run_op(8'h7F, 8'hFF, 0);
    run_op(8'h00, 8'h00, 0);
    run_op(8'd5, 8'd3, 3);
    run_op(8'hC4, 8'h3B, 0);

    // Abort an op in progress with reset.
    @(negedge clk);
    a8 = 8'h5A;
    b8 = 8'h13;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    cnt0 = done8_cnt;
    repeat (3) @(posedge clk);
    #1;
    check_eq("pre_abort_busy", busy8, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("abort_busy", busy8, 0);
    check_eq("abort_done", done8, 0);
    check_eq("abort_diff", diff8, 0);
    check_eq("abort_borrow", borrow8, 0);
    check_eq("abort_ovf", ovf8, 0);
    repeat (12) @(posedge clk);
    #1;
    check_eq("abort_no_done", done8_cnt - cnt0, 0);
    run_op(8'h5A, 8'h13, 0);

    // Reset and start together: start is dropped.
    @(negedge clk);
    rst = 1'b1;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start8 = 1'b0;
    check_eq("rst_start_busy", busy8, 0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_start_idle", busy8, 0);

    // Exhaustive WIDTH=4 sweep with start held high between ops.
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      a4 = i[7:4];
      b4 = i[3:0];
      start4 = 1'b1;
      @(posedge clk);
      q4.push_back(model(4, i / 16, i % 16));
      repeat (5) @(posedge clk);
    end
    @(negedge clk);
    start4 = 1'b0;

    t = 0;
    while ((q8.size() != 0 || q4.size() != 0) && t < 100) begin
      @(posedge clk);
      t++;
    end
    repeat (2) @(posedge clk);
    #2;
    check_eq("drain", q8.size() + q4.size(), 0);
    check_eq("done4_total", done4_cnt, 256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
